// File: rtl/bcd_scan_display_if.sv
// bcd_scan_display_if: bundle between host logic and the 7-segment scan driver.
// The host drives the capture controls; the driver returns the pin-level outputs.
interface bcd_scan_display_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    enable;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] bcd_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [6:0]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    frame_done;

  modport master (
    output enable, load, bcd_in, dp_in,
    input  seg, dp, digit_en, frame_done
  );

  modport slave (
    input  enable, load, bcd_in, dp_in,
    output seg, dp, digit_en, frame_done
  );
endinterface

// File: rtl/bcd_scan_display.sv
// bcd_scan_display: time-multiplexed driver for an N-digit 7-segment display.
// A shadow register holds the BCD word and decimal points. A DISP/BLANK FSM walks
// the digits, and every pin comes straight from a register so the display never glitches.
// Optional build macro BCD_SCAN_LZB_EN enables leading-zero blanking.
module bcd_scan_display #(
  parameter int NUM_DIGITS       = 4,
  parameter int SCAN_DIV         = 1000,
  parameter int BLANK_CYCLES     = 2,
  parameter int SEG_ACTIVE_LOW   = 0,
  parameter int DIGIT_ACTIVE_LOW = 0
) (
  input logic               clk,
  input logic               rst_n,
  bcd_scan_display_if.slave bus
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DISP_LAST = CNT_W'(SCAN_DIV - BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic {DISP, BLANK} state_t;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic [IDX_W-1:0]        idx, idx_nxt;
  logic                    wrap, wrap_nxt;
  logic [4*NUM_DIGITS-1:0] shadow_bcd;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic [3:0]              cur_digit;
  logic [6:0]              seg_nxt, seg_q;
  logic                    dp_nxt, dp_q;
  logic [NUM_DIGITS-1:0]   digit_nxt, digit_q;
  logic                    frame_nxt, frame_q;

  // Logical (active-high) segment pattern, bit6=a .. bit0=g; non-BCD codes go dark.
  function automatic logic [6:0] decode(input logic [3:0] code);
    case (code)
      4'd0:    decode = 7'b1111110;
      4'd1:    decode = 7'b0110000;
      4'd2:    decode = 7'b1101101;
      4'd3:    decode = 7'b1111001;
      4'd4:    decode = 7'b0110011;
      4'd5:    decode = 7'b1011011;
      4'd6:    decode = 7'b1011111;
      4'd7:    decode = 7'b1110000;
      4'd8:    decode = 7'b1111111;
      4'd9:    decode = 7'b1111011;
      default: decode = 7'b0000000;
    endcase
  endfunction

  // Shadow register captures the host word whenever load is high, even while scanning is disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_bcd <= '0;
      shadow_dp  <= '0;
    end else if (bus.load) begin
      shadow_bcd <= bus.bcd_in;
      shadow_dp  <= bus.dp_in;
    end
  end

  // Scan state register: slot counter, digit index and the wrap marker that schedules frame_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= DISP;
      cnt   <= '0;
      idx   <= '0;
      wrap  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      wrap  <= wrap_nxt;
    end
  end

  // Next-state logic: DISP covers the first part of each slot and BLANK the tail; disabling parks the scan at digit 0.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    wrap_nxt  = 1'b0;
    if (!bus.enable) begin
      state_nxt = DISP;
      cnt_nxt   = '0;
      idx_nxt   = '0;
    end else if (cnt == CNT_LAST) begin
      cnt_nxt   = '0;
      state_nxt = DISP;
      if (idx == IDX_LAST) begin
        idx_nxt  = '0;
        wrap_nxt = 1'b1;
      end else begin
        idx_nxt = idx + 1'b1;
      end
    end else begin
      cnt_nxt   = cnt + 1'b1;
      state_nxt = (cnt >= DISP_LAST) ? BLANK : DISP;
    end
  end

`ifdef BCD_SCAN_LZB_EN
  logic [NUM_DIGITS-1:0] lzb_mask;
  logic                  zero_run;

  // A digit is suppressed when it and every digit above it are zero; digit 0 is never suppressed.
  always_comb begin
    lzb_mask = '0;
    zero_run = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run    = zero_run && (shadow_bcd[4*k +: 4] == 4'd0);
      lzb_mask[k] = zero_run && (k != 0);
    end
  end
`endif

  // Output decode: values the pins will take on the next edge, derived from the current scan state.
  always_comb begin
    cur_digit = shadow_bcd[4*idx +: 4];
    seg_nxt   = '0;
    dp_nxt    = 1'b0;
    digit_nxt = '0;
    frame_nxt = 1'b0;
    if (bus.enable && state == DISP) begin
`ifdef BCD_SCAN_LZB_EN
      if (!lzb_mask[idx]) seg_nxt = decode(cur_digit);
`else
      seg_nxt = decode(cur_digit);
`endif
      dp_nxt         = shadow_dp[idx];
      digit_nxt[idx] = 1'b1;
      frame_nxt      = wrap;
    end
  end

  // Output register: every pin is driven from a flop; reset forces all of them to their inactive level at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q   <= '0;
      dp_q    <= 1'b0;
      digit_q <= '0;
      frame_q <= 1'b0;
    end else begin
      seg_q   <= seg_nxt;
      dp_q    <= dp_nxt;
      digit_q <= digit_nxt;
      frame_q <= frame_nxt;
    end
  end

  assign bus.seg        = (SEG_ACTIVE_LOW != 0) ? ~seg_q : seg_q;
  assign bus.dp         = (SEG_ACTIVE_LOW != 0) ? ~dp_q : dp_q;
  assign bus.digit_en   = (DIGIT_ACTIVE_LOW != 0) ? ~digit_q : digit_q;
  assign bus.frame_done = frame_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// tb_bcd_scan_display: directed bench for a 4-digit scan with 8-cycle slots
// (6 display + 2 blank). All expected patterns are written out by hand.
module tb_bcd_scan_display;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

`ifdef BCD_SCAN_LZB_EN
  localparam logic [6:0] ZHI = 7'b0000000;
`else
  localparam logic [6:0] ZHI = 7'b1111110;
`endif

  bcd_scan_display_if #(.NUM_DIGITS(4)) bus ();

  bcd_scan_display #(
    .NUM_DIGITS(4),
    .SCAN_DIV(8),
    .BLANK_CYCLES(2),
    .SEG_ACTIVE_LOW(0),
    .DIGIT_ACTIVE_LOW(0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  // Free-running 10-time-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus(input logic en, input logic ld, input logic [15:0] bcd, input logic [3:0] dpv);
    bus.enable = en;
    bus.load   = ld;
    bus.bcd_in = bcd;
    bus.dp_in  = dpv;
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] expEn, input logic [6:0] expSeg,
                             input logic expDp, input logic expFd);
    checks++;
    assert (bus.digit_en === expEn) else begin
      errors++;
      $error("[TB] FAIL %s digit_en at %0t: got %b expected %b", tag, $time, bus.digit_en, expEn);
    end
    checks++;
    assert (bus.seg === expSeg) else begin
      errors++;
      $error("[TB] FAIL %s seg at %0t: got %b expected %b", tag, $time, bus.seg, expSeg);
    end
    checks++;
    assert (bus.dp === expDp) else begin
      errors++;
      $error("[TB] FAIL %s dp at %0t: got %b expected %b", tag, $time, bus.dp, expDp);
    end
    checks++;
    assert (bus.frame_done === expFd) else begin
      errors++;
      $error("[TB] FAIL %s frame_done at %0t: got %b expected %b", tag, $time, bus.frame_done, expFd);
    end
  endtask

  // Walk n output cycles starting at the first cycle of digit 0; slot = 6 display + 2 blank.
  task automatic checkSlots(input string tag, input int n, input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3, input logic [3:0] dps,
                            input bit firstIsFrame);
    logic [6:0] segs [4];
    segs[0] = s0;
    segs[1] = s1;
    segs[2] = s2;
    segs[3] = s3;
    for (int c = 0; c < n; c++) begin
      int pos;
      int d;
      int w;
      @(negedge clk);
      pos = c % 32;
      d   = pos / 8;
      w   = pos % 8;
      if (w < 6)
        checkOutput(tag, 4'b0001 << d, segs[d], dps[d], (pos == 0) && (c > 0 || firstIsFrame));
      else
        checkOutput(tag, 4'b0000, 7'b0000000, 1'b0, 1'b0);
    end
  endtask

  task automatic loadShadow(input logic [15:0] bcd, input logic [3:0] dpv);
    applyStimulus(1'b1, 1'b1, bcd, dpv);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, bcd, dpv);
  endtask

  // One disabled edge parks the scan; the next edge shows digit 0 again.
  task automatic restartScan();
    bus.enable = 1'b0;
    @(negedge clk);
    checkOutput("disabled", 4'b0000, 7'b0000000, 1'b0, 1'b0);
    bus.enable = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    applyStimulus(1'b1, 1'b0, 16'h0000, 4'b0000);

    #12;
    checkOutput("reset", 4'b0000, 7'b0000000, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] scan timing after reset");
    checkSlots("scan", 40, 7'b1111110, ZHI, ZHI, ZHI, 4'b0000, 1'b0);

    $display("[TB] decode 1234");
    loadShadow(16'h1234, 4'b0100);
    restartScan();
    checkSlots("dec1234", 32, 7'b0110011, 7'b1111001, 7'b1101101, 7'b0110000, 4'b0100, 1'b0);

    $display("[TB] invalid codes 00AF");
    loadShadow(16'h00AF, 4'b0000);
    restartScan();
    checkSlots("dec00AF", 32, 7'b0000000, 7'b0000000, ZHI, ZHI, 4'b0000, 1'b0);

    $display("[TB] asynchronous reset during digit 2");
    restartScan();
    repeat (18) @(negedge clk);
    checkOutput("rst_pre", 4'b0100, ZHI, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 checkOutput("rst_async", 4'b0000, 7'b0000000, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    checkSlots("rst_restart", 10, 7'b1111110, ZHI, ZHI, ZHI, 4'b0000, 1'b0);

    $display("[TB] enable dropped mid-slot");
    bus.enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("en_low", 4'b0000, 7'b0000000, 1'b0, 1'b0);
    end
    bus.enable = 1'b1;
    checkSlots("en_resume", 33, 7'b1111110, ZHI, ZHI, ZHI, 4'b0000, 1'b0);

    $display("[TB] load during digit 1");
    restartScan();
    repeat (11) @(negedge clk);
    checkOutput("ld_before", 4'b0010, ZHI, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 16'h9999, 4'b0000);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 16'h9999, 4'b0000);
    checkOutput("ld_edge1", 4'b0010, ZHI, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("ld_edge2", 4'b0010, 7'b1111011, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("ld_hold", 4'b0010, 7'b1111011, 1'b0, 1'b0);

`ifdef BCD_SCAN_LZB_EN
    $display("[TB] leading-zero blanking");
    loadShadow(16'h0045, 4'b0000);
    restartScan();
    checkSlots("lzb0045", 32, 7'b1011011, 7'b0110011, 7'b0000000, 7'b0000000, 4'b0000, 1'b0);
    loadShadow(16'h0000, 4'b0000);
    restartScan();
    checkSlots("lzb0000", 32, 7'b1111110, 7'b0000000, 7'b0000000, 7'b0000000, 4'b0000, 1'b0);
    loadShadow(16'h1005, 4'b0000);
    restartScan();
    checkSlots("lzb1005", 32, 7'b1011011, 7'b1111110, 7'b1111110, 7'b0110000, 4'b0000, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_scan_display.md
Name: bcd_scan_display

Overview:
Time-multiplexed driver for an N-digit common-anode/cathode 7-segment display.
- Captures a packed BCD word plus decimal points into a shadow register.
- Scans one digit at a time with a programmable dwell time and an anti-ghosting blank interval.
- Decodes each digit to segments a..g and drives the display pins directly.

Parameters:
- NUM_DIGITS, 4, digits scanned (1..8).
- SCAN_DIV, 1000, clk cycles per digit slot including blank (>= 2).
- BLANK_CYCLES, 2, cycles per slot with all digits off (0..SCAN_DIV-1; 0 = no BLANK state).
- SEG_ACTIVE_LOW, 0, 1 inverts seg and dp pins.
- DIGIT_ACTIVE_LOW, 0, 1 inverts digit_en pins.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  scan enable.
- load  input  1  capture bcd_in/dp_in into the shadow register.
- bcd_in  input  4*NUM_DIGITS  packed BCD; digit k = bcd_in[4k+3:4k], digit 0 = least significant.
- dp_in  input  NUM_DIGITS  decimal point per digit.
- seg  output  7  segments; bit6=a ... bit0=g.
- dp  output  1  decimal point of the active digit.
- digit_en  output  NUM_DIGITS  one-hot digit select.
- frame_done  output  1  one-cycle pulse per completed frame.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - Shadow register = 0; idx = 0; slot counter cnt = 0; state = DISP.
  - seg, dp and digit_en at their inactive levels; frame_done = 0.
- Shadow register: on a rising edge with load=1, captures bcd_in and dp_in. Updated values appear on the outputs on the edge after capture (1-cycle latency).
- Decode, at logical (active-high) level:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
  - Codes 10..15 = 0000000. dp is not suppressed for these codes.
- FSM, states DISP and BLANK; cnt counts 0..SCAN_DIV-1 within a slot:
  - DISP: digit_en[idx] active; seg/dp show shadow digit idx. Lasts SCAN_DIV-BLANK_CYCLES cycles, then goes to BLANK (or straight to the next slot if BLANK_CYCLES=0).
  - BLANK: all digit_en inactive; seg and dp inactive. Lasts BLANK_CYCLES cycles.
  - End of slot: cnt returns to 0; idx increments and wraps NUM_DIGITS-1 -> 0; state = DISP.
  - frame_done pulses high for exactly one cycle, coincident with the first output cycle of digit 0 after a wrap. It does not pulse after reset.
- Output timing: all outputs are registered. Pins reflect the FSM state one cycle later. The first DISP cycle of digit 0 appears on the first rising edge after reset release (with enable=1).
- enable=0:
  - On the next edge, idx, cnt and state are synchronously returned to their reset values.
  - All display outputs go inactive; frame_done = 0.
  - The shadow register still loads.
  - When enable returns to 1, the scan restarts at digit 0 as after reset.
- digit_en is never multi-hot, in any cycle, under any parameter set.
- Polarity: the inversion parameters apply only at the pins; all rules above are stated at logical level.
- Reset mid-scan: outputs go inactive immediately (asynchronously); the scan restarts at digit 0 when reset is released.

Optional Feature:
- Macro: BCD_SCAN_LZB_EN.
- Defined: leading-zero blanking.
  - Digit k is blanked (seg = inactive) if the shadow value is 0 for digit k and for every higher digit, and k != 0.
  - Digit 0 always displays.
  - digit_en timing is unchanged; dp is unaffected.
  - Evaluated on shadow contents, combinationally ahead of the output register.
- Undefined: all digits are decoded normally; no extra logic is present.

Test Plan (NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2, active-high, enable=1 unless stated):
- Reset/scan timing: release rst_n -> digit_en = 0001 for 6 cycles, 0000 for 2, then 0010, 0100, 1000 with the same pattern; frame_done pulses once every 32 cycles, coincident with 0001.
- Decode: load bcd_in=16'h1234, dp_in=4'b0100 -> digit0 seg=0110011; digit1 seg=1111001; digit2 seg=1101101 with dp=1; digit3 seg=0110000; all seg=0 during BLANK cycles.
- Invalid code: load 16'h00AF -> digit0 and digit1 seg=0000000; digits 2..3 seg=1111110 (macro undefined).
- Mid-scan events:
  - Assert rst_n=0 during digit 2 -> digit_en=0000 and seg=0 without waiting for a clock edge; after release, the scan restarts at digit 0.
  - Drop enable for 3 cycles mid-slot -> outputs inactive; scan resumes at digit 0 with full slot timing.
- Load during scan: load 16'h9999 in the middle of digit 1's DISP window -> seg changes to 1111011 on the second edge after load, without a slot restart.
- BCD_SCAN_LZB_EN defined:
  - Load 16'h0045 -> digits 3,2 seg=0, digit1=0110011, digit0=1011011.
  - Load 16'h0000 -> only digit0 shows 1111110.
  - Load 16'h1005 -> no digits blanked.
